// File: rtl/imem_loader_if.sv
// Byte-stream handshake and instruction-memory write port between a host
// byte source and the instruction memory image loader.
interface imem_loader_if;
    logic [7:0]  byte_in;
    logic        byte_valid;
    logic        byte_ready;
    logic        imem_we;
    logic [31:0] imem_waddr;
    logic [31:0] imem_wdata;

    // Host side: drives the byte stream, observes memory writes.
    modport master (
        output byte_in,
        output byte_valid,
        input  byte_ready,
        input  imem_we,
        input  imem_waddr,
        input  imem_wdata
    );

    // Loader side: consumes the byte stream, drives memory writes.
    modport slave (
        input  byte_in,
        input  byte_valid,
        output byte_ready,
        output imem_we,
        output imem_waddr,
        output imem_wdata
    );
endinterface

// File: rtl/imem_loader.sv
// Instruction memory loader: packs a little-endian byte stream into 32-bit words,
// writes them from address 0 upward and holds the core in reset until the image is complete.
module imem_loader #(
    parameter int unsigned MEM_WORDS = 256,
    parameter int unsigned CNT_W     = $clog2(MEM_WORDS) + 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [CNT_W-1:0]     num_words,
    imem_loader_if.slave         bus,
    output logic                 core_rst,
    output logic                 busy,
    output logic                 done,
    output logic                 error,
    output logic [31:0]          checksum
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RECV  = 2'd1,
        WRITE = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t           state;
    logic [CNT_W-1:0] count;
    logic [CNT_W-1:0] word_idx;
    logic [1:0]       byte_idx;
    logic [23:0]      word_buf;

    logic num_ok_c;
    logic xfer_c;
    logic last_word_c;

    assign num_ok_c    = (num_words != '0) && (num_words <= CNT_W'(MEM_WORDS));
    assign xfer_c      = bus.byte_valid && bus.byte_ready;
    assign last_word_c = (word_idx == (count - CNT_W'(1)));

    // Single-process FSM; every output is a register updated alongside the state.
    always_ff @(posedge clk) begin
        if (rst) begin
            state          <= IDLE;
            count          <= '0;
            word_idx       <= '0;
            byte_idx       <= '0;
            word_buf       <= '0;
            bus.byte_ready <= 1'b0;
            bus.imem_we    <= 1'b0;
            bus.imem_waddr <= '0;
            bus.imem_wdata <= '0;
            core_rst       <= 1'b1;
            busy           <= 1'b0;
            done           <= 1'b0;
            error          <= 1'b0;
            checksum       <= '0;
        end else begin
            bus.imem_we <= 1'b0;
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        if (num_ok_c) begin
                            count          <= num_words;
                            word_idx       <= '0;
                            byte_idx       <= '0;
                            checksum       <= '0;
                            error          <= 1'b0;
                            done           <= 1'b0;
                            busy           <= 1'b1;
                            core_rst       <= 1'b1;
                            bus.byte_ready <= 1'b1;
                            state          <= RECV;
                        end else begin
                            // Rejected request leaves the current state and image intact.
                            error <= 1'b1;
                        end
                    end
                end

                RECV: begin
                    if (xfer_c) begin
                        byte_idx <= byte_idx + 2'd1;
                        case (byte_idx)
                            2'd0: word_buf[7:0]   <= bus.byte_in;
                            2'd1: word_buf[15:8]  <= bus.byte_in;
                            2'd2: word_buf[23:16] <= bus.byte_in;
                            default: begin
                                bus.imem_we    <= 1'b1;
                                bus.imem_waddr <= 32'({word_idx, 2'b00});
                                bus.imem_wdata <= {bus.byte_in, word_buf};
                                bus.byte_ready <= 1'b0;
                                state          <= WRITE;
                            end
                        endcase
                    end
                end

                WRITE: begin
                    checksum <= checksum + bus.imem_wdata;
                    if (last_word_c) begin
                        busy     <= 1'b0;
                        done     <= 1'b1;
                        core_rst <= 1'b0;
                        state    <= DONE;
                    end else begin
                        word_idx       <= word_idx + CNT_W'(1);
                        bus.byte_ready <= 1'b1;
                        state          <= RECV;
                    end
                end

                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_imem_loader.sv
// Self-checking bench for imem_loader: random images streamed with varied valid
// patterns, checked against a word-list/address/checksum model of the load.
module tb_imem_loader;
    localparam int unsigned MEM_WORDS = 256;
    localparam int unsigned CNT_W     = $clog2(MEM_WORDS) + 1;

    logic             clk = 1'b0;
    logic             rst;
    logic             start;
    logic [CNT_W-1:0] num_words;
    logic             core_rst;
    logic             busy;
    logic             done;
    logic             error;
    logic [31:0]      checksum;

    imem_loader_if bus();

    imem_loader #(.MEM_WORDS(MEM_WORDS), .CNT_W(CNT_W)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .num_words (num_words),
        .bus       (bus.slave),
        .core_rst  (core_rst),
        .busy      (busy),
        .done      (done),
        .error     (error),
        .checksum  (checksum)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    logic [31:0] exp_words[$];
    logic [63:0] wq[$];
    int          glitches = 0;
    logic        prev_we  = 1'b0;

    // Write log and strobe-width watcher, sampled mid-cycle.
    always @(negedge clk) begin
        if (bus.imem_we) wq.push_back({bus.imem_waddr, bus.imem_wdata});
        if (bus.imem_we && prev_we) glitches <= glitches + 1;
        prev_we <= bus.imem_we;
    end

    task automatic gen_words(input int n);
        exp_words.delete();
        for (int i = 0; i < n; i++) exp_words.push_back($urandom);
    endtask

    // Streams the first nbytes of exp_words; mode 0 always valid, 1 alternating, 2 random.
    task automatic stream(input int nbytes, input int mode, input bit poke, output int got);
        int   cyc = 0;
        bit   v;
        bit   r;
        logic [31:0] w;
        got = 0;
        while (got < nbytes && cyc < 40 * nbytes + 100) begin
            w = exp_words[got / 4];
            bus.byte_in    = w[8 * (got % 4) +: 8];
            v              = (mode == 0) ? 1'b1 : (mode == 1) ? (cyc % 2 == 0) : ($urandom_range(0, 2) != 0);
            bus.byte_valid = v;
            if (poke && cyc == 3) begin
                start     = 1'b1;
                num_words = '0;
            end
            r = bus.byte_ready;
            @(posedge clk); #1;
            start = 1'b0;
            cyc++;
            if (v && r) begin
                got++;
                if (got % 4 == 0) begin
                    checks++;
                    if (bus.imem_we !== 1'b1 || bus.imem_waddr !== 32'(4 * (got / 4 - 1)) || bus.imem_wdata !== w) begin
                        errors++;
                        $display("FAIL write_latency word %0d: we=%b addr=%h data=%h, expected we=1 addr=%h data=%h",
                                 got / 4 - 1, bus.imem_we, bus.imem_waddr, bus.imem_wdata, 32'(4 * (got / 4 - 1)), w);
                    end
                end
            end
        end
        bus.byte_valid = 1'b0;
        if (got < nbytes) begin
            checks++;
            errors++;
            $display("FAIL stream_timeout: transferred %0d bytes, expected %0d", got, nbytes);
        end
    endtask

    task automatic run_load(input int n, input int mode, input bit poke);
        int          base = wq.size();
        int          got;
        logic [31:0] sum = '0;
        for (int i = 0; i < n; i++) sum += exp_words[i];
        start     = 1'b1;
        num_words = CNT_W'(n);
        @(posedge clk); #1;
        start = 1'b0;
        checks++;
        if ({busy, core_rst, done, error, bus.byte_ready} !== 5'b11001 || checksum !== 32'h0) begin
            errors++;
            $display("FAIL load_start: busy=%b core_rst=%b done=%b error=%b ready=%b cs=%h, expected 1 1 0 0 1 0",
                     busy, core_rst, done, error, bus.byte_ready, checksum);
        end
        stream(4 * n, mode, poke, got);
        @(posedge clk); #1;
        checks++;
        if ({done, busy, core_rst, bus.byte_ready, bus.imem_we, error} !== 6'b100000) begin
            errors++;
            $display("FAIL load_done_flags: done=%b busy=%b core_rst=%b ready=%b we=%b error=%b, expected 1 0 0 0 0 0",
                     done, busy, core_rst, bus.byte_ready, bus.imem_we, error);
        end
        checks++;
        if (checksum !== sum) begin
            errors++;
            $display("FAIL load_checksum: got %h, expected %h", checksum, sum);
        end
        checks++;
        if (wq.size() - base !== n) begin
            errors++;
            $display("FAIL write_count: got %0d writes, expected %0d", wq.size() - base, n);
        end else begin
            for (int i = 0; i < n; i++) begin
                checks++;
                if (wq[base + i] !== {32'(4 * i), exp_words[i]}) begin
                    errors++;
                    $display("FAIL write_log %0d: got %h, expected %h", i, wq[base + i], {32'(4 * i), exp_words[i]});
                end
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if ({core_rst, busy, done, error, bus.byte_ready, bus.imem_we} !== 6'b100000 ||
            bus.imem_waddr !== 32'h0 || bus.imem_wdata !== 32'h0 || checksum !== 32'h0) begin
            errors++;
            $display("FAIL reset_values: core_rst=%b busy=%b done=%b error=%b ready=%b we=%b addr=%h data=%h cs=%h, expected 1 0 0 0 0 0 0 0 0",
                     core_rst, busy, done, error, bus.byte_ready, bus.imem_we, bus.imem_waddr, bus.imem_wdata, checksum);
        end
        rst = 1'b0;
    endtask

    task automatic test_basic();
        exp_words = '{32'h0050_0013, 32'h0010_0093};
        run_load(2, 0, 1'b0);
        checks++;
        if (checksum !== 32'h0060_00A6) begin
            errors++;
            $display("FAIL basic_checksum: got %h, expected 006000a6", checksum);
        end
    endtask

    task automatic test_valid_toggle();
        exp_words = '{32'h0050_0013, 32'h0010_0093};
        run_load(2, 1, 1'b0);
    endtask

    task automatic test_error();
        int base;
        test_reset();
        base = wq.size();
        for (int k = 0; k < 2; k++) begin
            start     = 1'b1;
            num_words = (k == 0) ? CNT_W'(0) : CNT_W'(MEM_WORDS + 1);
            @(posedge clk); #1;
            start = 1'b0;
            checks++;
            if ({error, core_rst, bus.byte_ready, busy, done} !== 5'b11000) begin
                errors++;
                $display("FAIL reject_idle %0d: error=%b core_rst=%b ready=%b busy=%b done=%b, expected 1 1 0 0 0",
                         k, error, core_rst, bus.byte_ready, busy, done);
            end
        end
        bus.byte_valid = 1'b1;
        repeat (6) @(posedge clk);
        #1;
        bus.byte_valid = 1'b0;
        checks++;
        if (wq.size() !== base || bus.byte_ready !== 1'b0) begin
            errors++;
            $display("FAIL reject_no_write: writes=%0d ready=%b, expected 0 0", wq.size() - base, bus.byte_ready);
        end
        gen_words(1);
        run_load(1, 2, 1'b0);
        start     = 1'b1;
        num_words = '0;
        @(posedge clk); #1;
        start = 1'b0;
        checks++;
        if ({error, done, core_rst, busy} !== 4'b1100) begin
            errors++;
            $display("FAIL reject_done: error=%b done=%b core_rst=%b busy=%b, expected 1 1 0 0", error, done, core_rst, busy);
        end
    endtask

    task automatic test_random();
        int n;
        for (int t = 0; t < 6; t++) begin
            n = $urandom_range(1, 8);
            gen_words(n);
            run_load(n, 2, n >= 2);
        end
    endtask

    task automatic test_full();
        int base;
        gen_words(MEM_WORDS);
        run_load(MEM_WORDS, 0, 1'b0);
        checks++;
        if (wq[wq.size() - 1][63:32] !== 32'h0000_03FC) begin
            errors++;
            $display("FAIL full_last_addr: got %h, expected 000003fc", wq[wq.size() - 1][63:32]);
        end
        base = wq.size();
        bus.byte_valid = 1'b1;
        for (int i = 0; i < 8; i++) begin
            bus.byte_in = 8'($urandom);
            @(posedge clk); #1;
            checks++;
            if (bus.byte_ready !== 1'b0 || done !== 1'b1) begin
                errors++;
                $display("FAIL full_extra_bytes cycle %0d: ready=%b done=%b, expected 0 1", i, bus.byte_ready, done);
            end
        end
        bus.byte_valid = 1'b0;
        checks++;
        if (wq.size() !== base) begin
            errors++;
            $display("FAIL full_no_wrap: %0d extra writes, expected 0", wq.size() - base);
        end
    endtask

    task automatic test_rst_mid();
        int base;
        int got;
        gen_words(3);
        base      = wq.size();
        start     = 1'b1;
        num_words = CNT_W'(3);
        @(posedge clk); #1;
        start = 1'b0;
        stream(6, 0, 1'b0, got);
        rst = 1'b1;
        @(posedge clk); #1;
        checks++;
        if ({core_rst, busy, done, error, bus.byte_ready, bus.imem_we} !== 6'b100000 ||
            bus.imem_waddr !== 32'h0 || bus.imem_wdata !== 32'h0 || checksum !== 32'h0) begin
            errors++;
            $display("FAIL rst_mid_values: core_rst=%b busy=%b done=%b error=%b ready=%b we=%b addr=%h data=%h cs=%h, expected 1 0 0 0 0 0 0 0 0",
                     core_rst, busy, done, error, bus.byte_ready, bus.imem_we, bus.imem_waddr, bus.imem_wdata, checksum);
        end
        rst = 1'b0;
        checks++;
        if (wq.size() - base !== 1 || wq[base] !== {32'h0, exp_words[0]}) begin
            errors++;
            $display("FAIL rst_mid_writes: count=%0d first=%h, expected 1 %h", wq.size() - base, wq[base], {32'h0, exp_words[0]});
        end
    endtask

    task automatic test_restart();
        gen_words(2);
        run_load(2, 0, 1'b0);
        gen_words(1);
        run_load(1, 2, 1'b0);
        checks++;
        if (checksum !== exp_words[0]) begin
            errors++;
            $display("FAIL restart_checksum: got %h, expected %h", checksum, exp_words[0]);
        end
    endtask

    initial begin
        bus.byte_in    = '0;
        bus.byte_valid = 1'b0;
        start          = 1'b0;
        num_words      = '0;
        rst            = 1'b1;
        test_reset();
        test_basic();
        test_valid_toggle();
        test_error();
        test_random();
        test_full();
        test_rst_mid();
        test_restart();
        @(posedge clk); #1;
        checks++;
        if (glitches !== 0) begin
            errors++;
            $display("FAIL we_pulse_width: %0d multi-cycle strobes, expected 0", glitches);
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
